// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the receiver and transmitter.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 104;
endpackage

// File: rtl/rx_line_cond.sv
// rx_line_cond: 2-flop synchronizer for the rx pin, plus a 2-of-3 majority glitch filter
// when UART_RX_GLITCH_FILTER_EN is defined.
module rx_line_cond (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic line
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx};
    end
`ifdef UART_RX_GLITCH_FILTER_EN
    // The window is the synchronizer output plus two older samples, so it adds one cycle of delay.
    logic [1:0] flt_q;
    logic [2:0] win;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) flt_q <= 2'b11;
        else     flt_q <= {flt_q[0], sync_q[1]};
    end
    assign win  = {flt_q, sync_q[1]};
    assign line = (win[0] & win[1]) | (win[1] & win[2]) | (win[0] & win[2]);
`else
    assign line = sync_q[1];
`endif
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, CLKS_PER_BIT clocks per bit; the optional glitch
// filter is enabled by UART_RX_GLITCH_FILTER_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       framing_error,
    output logic       is_receiving
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic           line;
    uart_rx_state_t state_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     idx_q;
    logic [7:0]     sh_q;
    logic [7:0]     rx_byte_q;
    logic           received_q;
    logic           framing_error_q;
    logic           is_receiving_q;

    rx_line_cond u_cond (.clk(clk), .rst(rst), .rx(rx), .line(line));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            sh_q            <= '0;
            rx_byte_q       <= '0;
            received_q      <= 1'b0;
            framing_error_q <= 1'b0;
            is_receiving_q  <= 1'b0;
        end else begin
            received_q      <= 1'b0;
            framing_error_q <= 1'b0;
            case (state_q)
                IDLE: if (!line) begin
                    state_q        <= START;
                    cnt_q          <= HALF;
                    is_receiving_q <= 1'b1;
                end
                START: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                else if (line) begin
                    state_q        <= IDLE;
                    is_receiving_q <= 1'b0;
                end else begin
                    state_q <= DATA;
                    cnt_q   <= FULL;
                    idx_q   <= '0;
                end
                DATA: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                else begin
                    sh_q  <= {line, sh_q[7:1]};
                    cnt_q <= FULL;
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd7) state_q <= STOP;
                end
                STOP: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                else if (line) begin
                    rx_byte_q      <= sh_q;
                    received_q     <= 1'b1;
                    state_q        <= IDLE;
                    is_receiving_q <= 1'b0;
                end else begin
                    framing_error_q <= 1'b1;
                    state_q         <= BREAK;
                end
                // A line stuck low after a bad stop bit must not look like a new start.
                BREAK: if (line) begin
                    state_q        <= IDLE;
                    is_receiving_q <= 1'b0;
                end
                default: begin
                    state_q        <= IDLE;
                    is_receiving_q <= 1'b0;
                end
            endcase
        end
    end

    assign received      = received_q;
    assign rx_byte       = rx_byte_q;
    assign framing_error = framing_error_q;
    assign is_receiving  = is_receiving_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed checks of uart_rx against a frame-timing reference model.
module tb_uart_rx;
    localparam int C = 16;
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int FLT = 1;
`else
    localparam int FLT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       received;
    logic [7:0] rx_byte;
    logic       framing_error;
    logic       is_receiving;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .rx(rx), .received(received), .rx_byte(rx_byte),
        .framing_error(framing_error), .is_receiving(is_receiving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Reference model: frame timing expressed as offsets from the edge that first sees the line low.
    logic       hist[$];
    logic       exp_rcv, exp_fe, exp_busy;
    logic [7:0] exp_byte;
    int         exp_rcv_cnt;

    function automatic logic line_at();
        int s = hist.size();
        logic a = (s >= 3) ? hist[s-3] : 1'b1;
        logic b = (s >= 4) ? hist[s-4] : 1'b1;
        logic c = (s >= 5) ? hist[s-5] : 1'b1;
        return (FLT != 0) ? ((a & b) | (b & c) | (a & c)) : a;
    endfunction

    initial begin
        logic       busy, brk, ln;
        logic [7:0] bits;
        int         t;
        busy = 0; brk = 0; t = 0; bits = 0;
        exp_rcv = 0; exp_fe = 0; exp_busy = 0; exp_byte = 0; exp_rcv_cnt = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                hist.delete();
                busy = 0; brk = 0;
                exp_rcv = 0; exp_fe = 0; exp_busy = 0; exp_byte = 0;
            end else begin
                hist.push_back(rx);
                ln = line_at();
                exp_rcv = 0; exp_fe = 0;
                if (!busy) begin
                    if (!ln) begin busy = 1; brk = 0; t = 0; end
                end else if (brk) begin
                    if (ln) busy = 0;
                end else begin
                    t++;
                    if (t == C/2) begin
                        if (ln) busy = 0;
                    end else if (t > C/2 && t < C/2 + 9*C && (t - C/2) % C == 0) begin
                        bits[(t - C/2) / C - 1] = ln;
                    end else if (t == C/2 + 9*C) begin
                        if (ln) begin exp_rcv = 1; exp_byte = bits; busy = 0; exp_rcv_cnt++; end
                        else begin exp_fe = 1; brk = 1; end
                    end
                end
                exp_busy = busy;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process and event monitor.
    int   rcv_cnt = 0, fe_cnt = 0;
    int   rcv_cyc[$];
    logic busy_seen = 0;
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("received", received, exp_rcv);
            chk("framing_error", framing_error, exp_fe);
            chk("rx_byte", rx_byte, exp_byte);
            chk("is_receiving", is_receiving, exp_busy);
            if (received) begin rcv_cnt++; rcv_cyc.push_back(cyc); end
            if (framing_error) fe_cnt++;
            if (is_receiving) busy_seen = 1;
        end
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        drive(1'b0, C);
        for (int i = 0; i < 8; i++) drive(b[i], C);
        drive(stop, C);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, r0, e0;
        @(negedge clk);
        chk("reset_rx_byte", rx_byte, 8'h00);
        chk("reset_is_receiving", is_receiving, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 20);

        f = cyc;
        send(8'h55, 1'b1);
        drive(1'b1, 20);
        chk("f55_count", rcv_cnt, 1);
        chk("f55_byte", rx_byte, 8'h55);
        chk("f55_no_fe", fe_cnt, 0);
        chk("f55_latency", rcv_cyc[0] - f, 155 + FLT);

        send(8'hA3, 1'b1);
        send(8'h0F, 1'b1);
        drive(1'b1, 20);
        chk("b2b_count", rcv_cnt, 3);
        chk("b2b_spacing", rcv_cyc[2] - rcv_cyc[1], 160);
        chk("b2b_byte", rx_byte, 8'h0F);

        drive(1'b0, 5);
        drive(1'b1, 40);
        chk("false_start_rcv", rcv_cnt, 3);
        chk("false_start_fe", fe_cnt, 0);
        chk("false_start_byte", rx_byte, 8'h0F);
        chk("false_start_idle", is_receiving, 0);

        send(8'h3C, 1'b0);
        drive(1'b0, 48);
        drive(1'b1, 16);
        chk("ferr_fe", fe_cnt, 1);
        chk("ferr_no_rcv", rcv_cnt, 3);
        chk("ferr_byte_held", rx_byte, 8'h0F);
        send(8'h81, 1'b1);
        drive(1'b1, 20);
        chk("after_ferr_rcv", rcv_cnt, 4);
        chk("after_ferr_byte", rx_byte, 8'h81);

        drive(1'b0, C);
        drive(1'b1, 4*C + C/2);
        rst = 1'b1;
        drive(1'b1, 4);
        chk("midframe_reset_byte", rx_byte, 8'h00);
        chk("midframe_reset_busy", is_receiving, 0);
        rst = 1'b0;
        drive(1'b1, 20);
        chk("aborted_no_rcv", rcv_cnt, 4);
        send(8'h12, 1'b1);
        drive(1'b1, 20);
        chk("after_reset_rcv", rcv_cnt, 5);
        chk("after_reset_byte", rx_byte, 8'h12);

        busy_seen = 0;
        drive(1'b0, 1);
        drive(1'b1, 30);
        chk("glitch_busy", busy_seen, (FLT != 0) ? 0 : 1);
        chk("glitch_no_rcv", rcv_cnt, 5);
        chk("glitch_no_fe", fe_cnt, 1);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0) drive(1'b0, $urandom_range(1, 6));
            drive(1'b1, $urandom_range(0, 3) == 0 ? 30 : 0);
            send(8'($urandom), $urandom_range(0, 7) != 0);
            drive(1'b1, $urandom_range(0, 24));
        end
        drive(1'b1, 40);
        chk("random_rcv_total", rcv_cnt, exp_rcv_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
